// File: rtl/goboard_switch_port.sv
// goboard_switch_port
//   Memory-mapped push-button input port for the Go Board CPU system.
//   Each of the four raw buttons passes through a 2-flop synchronizer and
//   a per-bit debouncer. A rising debounced level latches a sticky press
//   event and advances an 8-bit press counter. The CPU reads the level,
//   event and count registers over the data bus. It clears events by
//   writing 1 to the bits to clear, and clears the counter with any write.
//
// Ports
//   clk          12 MHz system clock
//   reset        synchronous, active-high
//   clk_en_i     CPU clock enable; qualifies bus writes
//   switch_i     raw buttons, asynchronous, 1 = pressed
//   addr_i       CPU data address
//   mem_write_i  CPU write strobe
//   wdata_i      CPU write data
//   hit_o        addr_i matches LEVEL/EVENT/COUNT address (combinational)
//   rdata_o      read data, 0 when no hit (combinational)
//   irq_o        registered OR of the event flags
module goboard_switch_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic [31:0] LEVEL_ADDR      = 32'h0000_0018,
  parameter logic [31:0] EVENT_ADDR      = 32'h0000_001C,
  parameter logic [31:0] COUNT_ADDR      = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en_i,
  input  logic [3:0]  switch_i,
  input  logic [31:0] addr_i,
  input  logic        mem_write_i,
  input  logic [31:0] wdata_i,
  output logic        hit_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    event_q, event_d;
  logic [7:0]    count_q, count_d;
  logic          irq_q;

  logic [3:0]    press;
  logic [2:0]    press_cnt;
  logic          wr_en;
  logic          hit_level, hit_event, hit_count;

  assign hit_level = (addr_i == LEVEL_ADDR);
  assign hit_event = (addr_i == EVENT_ADDR);
  assign hit_count = (addr_i == COUNT_ADDR);
  assign hit_o     = hit_level | hit_event | hit_count;
  assign wr_en     = mem_write_i & clk_en_i;

  // Debounce: the level follows the synchronized input only after the
  // input has differed from the level for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // A press is a rising level, detected on the edge that the level updates.
  assign press = level_d & ~level_q;

  always_comb begin
    press_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      press_cnt = press_cnt + {2'b00, press[i]};
    end
  end

  // A press landing on the same edge as a clear takes priority, so no
  // press is lost to a racing clear.
  always_comb begin
    event_d = event_q | press;
    count_d = count_q + {5'b0, press_cnt};
    if (wr_en && hit_event) begin
      event_d = (event_q & ~wdata_i[3:0]) | press;
    end
    if (wr_en && hit_count) begin
      count_d = {5'b0, press_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      event_q <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= switch_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      count_q <= count_d;
      irq_q   <= |event_q;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    rdata_o = '0;
    if (hit_level) begin
      rdata_o = {28'b0, level_q};
    end else if (hit_event) begin
      rdata_o = {28'b0, event_q};
    end else if (hit_count) begin
      rdata_o = {24'b0, count_q};
    end
  end

endmodule

// File: tb/tb_goboard_switch_port.sv
// tb_goboard_switch_port
//   Self-checking bench for goboard_switch_port with DEBOUNCE_CYCLES=4.
//   Expected register reads are queued as stimulus is applied and compared
//   when the bench drains the queue through the bus read path.
module tb_goboard_switch_port;

  logic        clk;
  logic        reset;
  logic        clk_en_i;
  logic [3:0]  switch_i;
  logic [31:0] addr_i;
  logic        mem_write_i;
  logic [31:0] wdata_i;
  logic        hit_o;
  logic [31:0] rdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  string       tag_q  [$];
  logic [31:0] addr_q [$];
  logic [31:0] data_q [$];

  goboard_switch_port #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en_i   (clk_en_i),
    .switch_i   (switch_i),
    .addr_i     (addr_i),
    .mem_write_i(mem_write_i),
    .wdata_i    (wdata_i),
    .hit_o      (hit_o),
    .rdata_o    (rdata_o),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_regs(input string tag, input logic [3:0] lvl,
                             input logic [3:0] evt, input logic [7:0] cnt);
    tag_q.push_back({tag, "_level"}); addr_q.push_back(32'h18); data_q.push_back({28'b0, lvl});
    tag_q.push_back({tag, "_event"}); addr_q.push_back(32'h1C); data_q.push_back({28'b0, evt});
    tag_q.push_back({tag, "_count"}); addr_q.push_back(32'h20); data_q.push_back({24'b0, cnt});
  endtask

  task automatic drain();
    string       t;
    logic [31:0] a, d;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      a = addr_q.pop_front();
      d = data_q.pop_front();
      addr_i = a;
      #1;
      check({t, "_rdata"}, rdata_o, d);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic en);
    addr_i      = a;
    wdata_i     = d;
    mem_write_i = 1'b1;
    clk_en_i    = en;
    step(1);
    mem_write_i = 1'b0;
    clk_en_i    = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    clk_en_i    = 1'b0;
    switch_i    = 4'h0;
    addr_i      = 32'h0;
    mem_write_i = 1'b0;
    wdata_i     = 32'h0;
    step(3);
    reset = 1'b0;
    step(1);

    // 1. reset state and address decode
    expect_regs("reset", 4'h0, 4'h0, 8'h00);
    drain();
    check("reset_irq", {31'b0, irq_o}, 32'd0);
    addr_i = 32'h14; #1;
    check("hit_0x14", {31'b0, hit_o}, 32'd0);
    check("rdata_0x14", rdata_o, 32'd0);
    addr_i = 32'h19; #1;
    check("hit_unaligned", {31'b0, hit_o}, 32'd0);
    addr_i = 32'h1C; #1;
    check("hit_0x1c", {31'b0, hit_o}, 32'd1);

    // 2. single press on bit 2: level rises on the 6th edge after driving
    switch_i = 4'b0100;
    step(5);
    expect_regs("press2_early", 4'h0, 4'h0, 8'h00);
    drain();
    step(1);
    expect_regs("press2", 4'h4, 4'h4, 8'h01);
    drain();
    check("press2_irq_lag", {31'b0, irq_o}, 32'd0);
    step(1);
    check("press2_irq", {31'b0, irq_o}, 32'd1);

    // 3. 3-cycle glitch on bit 0 is rejected; 4-cycle hold is accepted
    switch_i = 4'b0101;
    step(3);
    switch_i = 4'b0100;
    step(8);
    expect_regs("glitch0", 4'h4, 4'h4, 8'h01);
    drain();
    switch_i = 4'b0101;
    step(4);
    switch_i = 4'b0100;
    step(10);
    expect_regs("hold0", 4'h4, 4'h5, 8'h02);
    drain();

    // 4. write-1-to-clear, gated by clk_en_i; level register ignores writes
    bus_write(32'h1C, 32'h1, 1'b0);
    expect_regs("w1c_noen", 4'h4, 4'h5, 8'h02);
    drain();
    bus_write(32'h1C, 32'h1, 1'b1);
    expect_regs("w1c_en", 4'h4, 4'h4, 8'h02);
    drain();
    bus_write(32'h18, 32'hF, 1'b1);
    bus_write(32'h20, 32'h0, 1'b0);
    expect_regs("w_level", 4'h4, 4'h4, 8'h02);
    drain();
    bus_write(32'h1C, 32'h4, 1'b1);
    check("irq_hold", {31'b0, irq_o}, 32'd1);
    step(1);
    check("irq_clear", {31'b0, irq_o}, 32'd0);

    // 5. clear of event[1] on the same edge that a bit-1 press lands
    switch_i = 4'b0110;
    step(5);
    bus_write(32'h1C, 32'h2, 1'b1);
    expect_regs("race1", 4'h6, 4'h2, 8'h03);
    drain();
    switch_i = 4'b0000;
    step(10);
    expect_regs("release", 4'h0, 4'h2, 8'h03);
    drain();

    // 6. counter clear racing a press keeps the increment
    switch_i = 4'b0001;
    step(5);
    bus_write(32'h20, 32'hDEAD, 1'b1);
    expect_regs("cnt_race", 4'h1, 4'h3, 8'h01);
    drain();
    switch_i = 4'b0000;
    step(10);
    bus_write(32'h20, 32'h0, 1'b1);
    expect_regs("cnt_clr", 4'h0, 4'h3, 8'h00);
    drain();

    // 255 presses on bit 3, then one more to wrap
    for (int p = 0; p < 255; p++) begin
      switch_i = 4'b1000;
      step(6);
      switch_i = 4'b0000;
      step(6);
    end
    expect_regs("cnt255", 4'h0, 4'hB, 8'hFF);
    drain();
    switch_i = 4'b1000;
    step(6);
    switch_i = 4'b0000;
    step(6);
    expect_regs("cnt_wrap", 4'h0, 4'hB, 8'h00);
    drain();

    // reset in the middle of a debounce: nothing emerges afterwards
    switch_i = 4'b0001;
    step(3);
    reset    = 1'b1;
    switch_i = 4'b0000;
    step(1);
    reset = 1'b0;
    step(10);
    expect_regs("rst_mid", 4'h0, 4'h0, 8'h00);
    drain();
    check("rst_mid_irq", {31'b0, irq_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
